// File: rtl/nn_pkg.sv
// Shared widths and FSM encoding for the NN neuron datapath.
// Lanes are signed int8 packed four to a 32-bit word; lane k lives in bits [8k+7:8k].
package nn_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 8;
  localparam int WORD_W = LANES * LANE_W;
  localparam int PROD_W = 2 * LANE_W;
  localparam int ACC_W  = 32;

  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    FINISH = 2'd1,
    OUTPUT = 2'd2
  } nn_state_t;

  function automatic logic signed [LANE_W-1:0] lane_of(
    input logic [WORD_W-1:0] word,
    input int                k
  );
    return word[k*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/nn_dot4.sv
// Combinational four-lane signed int8 dot product, sign-extended and summed
// modulo 2^32. Shared with later NN stages.
module nn_dot4
  import nn_pkg::*;
(
  input  logic        [WORD_W-1:0] a,
  input  logic        [WORD_W-1:0] b,
  output logic signed [ACC_W-1:0]  dot
);

  always_comb begin
    logic signed [PROD_W-1:0] xa;
    logic signed [PROD_W-1:0] xb;
    logic signed [PROD_W-1:0] prod;
    dot  = '0;
    xa   = '0;
    xb   = '0;
    prod = '0;
    for (int k = 0; k < LANES; k++) begin
      xa   = PROD_W'(lane_of(a, k));
      xb   = PROD_W'(lane_of(b, k));
      prod = xa * xb;
      dot  = dot + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

endmodule

// File: rtl/nn_neuron_mac.sv
// Single neuron MAC: accumulates NUM_WORDS packed int8 words against stored
// weights, adds bias, shifts and emits one result. Macro NN_RELU_EN enables ReLU.
module nn_neuron_mac
  import nn_pkg::*;
#(
  parameter int NUM_WORDS = 4,
  parameter int OUT_SHIFT = 0,
  parameter int WA_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              w_we,
  input  logic [WA_W-1:0]   w_addr,
  input  logic [WORD_W-1:0] w_data,
  input  logic              bias_we,
  input  logic [ACC_W-1:0]  bias_data,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy
);

  localparam logic [WA_W-1:0] LAST_IDX  = WA_W'(NUM_WORDS - 1);
  localparam logic [WA_W:0]   NUM_WORDS_L = (WA_W+1)'(NUM_WORDS);

  nn_state_t               state;
  nn_state_t               state_nxt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] bias;
  logic signed [ACC_W-1:0] dot;
  logic signed [ACC_W-1:0] sum;
  logic [WA_W-1:0]         word_cnt;
  logic [WORD_W-1:0]       weight [NUM_WORDS];
  logic                    accept;
  logic                    last_word;
  logic                    handshake;
  logic                    w_addr_ok;

  // Final activation: ReLU with logical shift, or a plain arithmetic shift.
  function automatic logic [ACC_W-1:0] finalize(input logic signed [ACC_W-1:0] s);
    logic [ACC_W-1:0] u;
    u = s;
`ifdef NN_RELU_EN
    if (s < 0) return '0;
    return u >> OUT_SHIFT;
`else
    return ACC_W'(s >>> OUT_SHIFT);
`endif
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_word = (word_cnt == LAST_IDX);
  assign handshake = (state == OUTPUT) && out_ready;
  assign sum       = acc + bias;
  assign w_addr_ok = ({1'b0, w_addr} < NUM_WORDS_L);

  nn_dot4 u_dot4 (
    .a   (in_data),
    .b   (weight[word_cnt]),
    .dot (dot)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    unique case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_word) state_nxt = FINISH;
      end
      FINISH:  state_nxt = OUTPUT;
      OUTPUT:  if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulate / finish / output stage boundary
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ACCUM;
      acc       <= '0;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        acc      <= acc + dot;
        busy     <= 1'b1;
        word_cnt <= last_word ? '0 : word_cnt + 1'b1;
      end
      if (state == FINISH) begin
        out_data  <= finalize(sum);
        out_valid <= 1'b1;
      end
      if (handshake) begin
        out_valid <= 1'b0;
        acc       <= '0;
        busy      <= 1'b0;
      end
    end
  end

  // Parameter storage: a read in the same cycle as a write sees the old value.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      bias <= '0;
      for (int i = 0; i < NUM_WORDS; i++) weight[i] <= '0;
    end else begin
      if (bias_we) bias <= bias_data;
      if (w_we && w_addr_ok) weight[w_addr] <= w_data;
    end
  end

endmodule
